crp16_alu_result_stage: RTL and testbench
=========================================

Name: crp16_alu_result_stage

Overview:
Pipeline stage directly downstream of the CRP16 ALU: captures alu_out plus V/C/N/Z each cycle an ALU result is presented.
- Holds the architectural NZCV flag register and evaluates branch conditions from it.
- Buffers results toward writeback in a 2-entry skid buffer with valid/ready handshakes on both sides, so a writeback stall never drops an ALU result.

Parameters:
DATA_W, 16, result width; must match ALU output width.
RD_W, 3, destination register index width (8 GPRs).

Ports:
clk  in  1  system clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  ALU result valid this cycle
in_ready  out  1  stage can accept; registered, not combinational from out_ready
in_result  in  DATA_W  ALU alu_out
in_v  in  1  ALU overflow flag
in_c  in  1  ALU carry flag
in_n  in  1  ALU negative flag
in_z  in  1  ALU zero flag
in_rd  in  RD_W  destination register index
in_wr_en  in  1  result is written to register file
in_flag_we  in  1  instruction updates NZCV
out_valid  out  1  head entry valid toward writeback
out_ready  in  1  writeback accepts head entry
out_result  out  DATA_W  head entry result
out_rd  out  RD_W  head entry destination
out_wr_en  out  1  head entry register write enable
cond  in  3  branch condition select
cond_true  out  1  selected condition holds
flags  out  4  {N,Z,C,V} architectural flag register

Behaviour:
- Reset (async assert, sync-safe deassert):
  - Both buffer entries invalid; out_valid=0, in_ready=1.
  - out_result=0, out_rd=0, out_wr_en=0, flags=4'b0000.
- Accept: in_valid & in_ready at a rising edge. Pop: out_valid & out_ready at a rising edge.
- Buffer:
  - Main entry drives the out_* ports; skid entry catches one extra result when the downstream stalls.
  - Empty + accept: write main; out_valid=1 next cycle. Latency 1 cycle in→out.
  - Main valid, pop and accept same cycle: main takes new data; out_valid stays 1.
  - Main valid, no pop, accept: write skid; in_ready=0 next cycle.
  - Skid valid + pop: skid moves to main; skid invalid; in_ready=1 next cycle.
  - Skid valid: in_ready=0, so no accept is possible; in_valid is ignored.
  - Main valid, pop, no accept: main invalid next cycle.
- Ordering: strictly FIFO; results leave in accept order.
- Payload ports hold their value while out_valid=1 and out_ready=0.
- Full-throughput: 1 result/cycle when out_ready held 1.
- Flags:
  - Updated at the accept edge when in_flag_we=1: flags <= {in_n,in_z,in_c,in_v}. Unchanged otherwise.
  - Independent of out_ready; flags commit at execute, not writeback.
  - An accept with in_flag_we=0 leaves flags unchanged even if in_valid=1.
- cond_true: combinational from the flags register.
  - 000 always=1
  - 001 EQ=Z
  - 010 NE=~Z
  - 011 LT=N^V
  - 100 GE=~(N^V)
  - 101 LTU=~C (ALU sub carry = no-borrow)
  - 110 GEU=C
  - 111 never=0
- Reset mid-operation: all buffered entries discarded, flags cleared immediately; no partial pop is visible.
- in_* sampled only on accept; X on in_* while in_valid=0 must not propagate.

Optional Feature:
CRP16_FLAG_BYPASS_EN
- Defined: cond_true and the flags port see the incoming flags when the current cycle is an accept with in_flag_we=1, i.e. {in_n,in_z,in_c,in_v} bypass the register. This gives zero-cycle compare→branch.
- Undefined: cond_true and flags reflect only the registered value, one cycle after the accept. The flag register update itself is identical in both builds.

Test Plan:
- Reset then in_valid=1, in_result=16'h1234, in_rd=3, out_ready=1 → next cycle out_valid=1, out_result=16'h1234, out_rd=3; the cycle after, out_valid=0.
- Stream results 1,2,3,4 on consecutive cycles with out_ready=1 → outputs 1,2,3,4 on consecutive cycles, in_ready never 0.
- out_ready=0, push 16'hAAAA then 16'hBBBB → in_ready=0 after the second; a third push with value 16'hCCCC is not accepted. Raise out_ready → AAAA, BBBB, then CCCC once re-presented, in order.
- Accept with flag_we=1, flags from sub 5-7 (N=1,Z=0,C=0,V=0) → flags=4'b1000; cond=011 gives 1, cond=101 gives 1, cond=001 gives 0. Next accept with flag_we=0, N=0 → flags unchanged.
- Assert reset_n=0 mid-stall with both entries full → out_valid=0, in_ready=1, flags=0 immediately without waiting for a clock edge.
- With CRP16_FLAG_BYPASS_EN defined: accept with flag_we=1, Z=1, cond=001 → cond_true=1 in the same cycle. Undefined: cond_true=1 only one cycle later.

Source files
------------

// File: rtl/crp16_alu_result_stage.sv
// CRP16 ALU result stage: NZCV flag register, branch-condition evaluation and a
// 2-entry skid buffer toward writeback. Optional macro CRP16_FLAG_BYPASS_EN forwards accepted flags to cond_true/flags in the accept cycle.
module crp16_alu_result_stage #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_v,
    input  logic              in_c,
    input  logic              in_n,
    input  logic              in_z,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_wr_en,
    input  logic              in_flag_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_wr_en,
    input  logic [2:0]        cond,
    output logic              cond_true,
    output logic [3:0]        flags
);

    // state    | meaning
    // ST_EMPTY | no result buffered
    // ST_MAIN  | main entry valid, skid empty
    // ST_FULL  | main and skid entries valid; input stalled
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] main_result, skid_result;
    logic [RD_W-1:0]   main_rd, skid_rd;
    logic              main_wr_en, skid_wr_en;
    logic [3:0]        flags_q;
    logic [3:0]        flags_in;
    logic [3:0]        flags_vis;

    logic accept, pop;
    logic load_main_in, load_main_skid, load_skid;

    // Handshake qualifiers are decoded from the state register only, so
    // in_ready never depends combinationally on out_ready.
    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign flags_in  = {in_n, in_z, in_c, in_v};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    state_nxt    = ST_MAIN;
                end
            end
            ST_MAIN: begin
                if (pop && accept) begin
                    load_main_in = 1'b1;
                end else if (pop) begin
                    state_nxt = ST_EMPTY;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ST_MAIN;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Payload registers load only on accept/shift, so X on idle inputs never reaches them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_result <= '0;
            main_rd     <= '0;
            main_wr_en  <= 1'b0;
            skid_result <= '0;
            skid_rd     <= '0;
            skid_wr_en  <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_result <= in_result;
                main_rd     <= in_rd;
                main_wr_en  <= in_wr_en;
            end else if (load_main_skid) begin
                main_result <= skid_result;
                main_rd     <= skid_rd;
                main_wr_en  <= skid_wr_en;
            end
            if (load_skid) begin
                skid_result <= in_result;
                skid_rd     <= in_rd;
                skid_wr_en  <= in_wr_en;
            end
        end
    end

    assign out_result = main_result;
    assign out_rd     = main_rd;
    assign out_wr_en  = main_wr_en;

    // Flags commit at accept, independent of writeback back-pressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= 4'b0000;
        end else if (accept && in_flag_we) begin
            flags_q <= flags_in;
        end
    end

`ifdef CRP16_FLAG_BYPASS_EN
    assign flags_vis = (accept && in_flag_we) ? flags_in : flags_q;
`else
    assign flags_vis = flags_q;
`endif

    assign flags = flags_vis;

    // flags_vis bit order is {N, Z, C, V}; carry means no-borrow after subtract.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = flags_vis[2];
            3'b010:  cond_true = ~flags_vis[2];
            3'b011:  cond_true = flags_vis[3] ^ flags_vis[0];
            3'b100:  cond_true = ~(flags_vis[3] ^ flags_vis[0]);
            3'b101:  cond_true = ~flags_vis[1];
            3'b110:  cond_true = flags_vis[1];
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_crp16_alu_result_stage.sv
// Self-checking bench for crp16_alu_result_stage: queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_crp16_alu_result_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_result = '0;
    logic        in_v = 1'b0, in_c = 1'b0, in_n = 1'b0, in_z = 1'b0;
    logic [2:0]  in_rd = '0;
    logic        in_wr_en = 1'b0;
    logic        in_flag_we = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_result;
    logic [2:0]  out_rd;
    logic        out_wr_en;
    logic [2:0]  cond = '0;
    logic        cond_true;
    logic [3:0]  flags;

    crp16_alu_result_stage #(.DATA_W(16), .RD_W(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_v(in_v), .in_c(in_c), .in_n(in_n), .in_z(in_z),
        .in_rd(in_rd), .in_wr_en(in_wr_en), .in_flag_we(in_flag_we),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_wr_en(out_wr_en),
        .cond(cond), .cond_true(cond_true), .flags(flags)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

`ifdef CRP16_FLAG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Branch predicate from an {N,Z,C,V} value, written as plain boolean rules.
    function automatic logic cond_eval(input logic [3:0] f, input logic [2:0] c);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return n != v;
            3'd4: return n == v;
            3'd5: return !cy;
            3'd6: return cy;
            default: return 1'b0;
        endcase
    endfunction

    typedef struct packed {
        logic [15:0] result;
        logic [2:0]  rd;
        logic        wr_en;
    } entry_t;

    entry_t     q[$];
    logic [3:0] m_flags = 4'b0;

    // Reference: a FIFO of at most two results plus a flag register.
    always @(posedge clk or negedge reset_n) begin : model
        bit acc, pp;
        if (!reset_n) begin
            q.delete();
            m_flags = 4'b0;
        end else begin
            acc = in_valid && (q.size() < 2);
            pp  = out_ready && (q.size() > 0);
            if (acc && in_flag_we) m_flags = {in_n, in_z, in_c, in_v};
            if (pp) void'(q.pop_front());
            if (acc) q.push_back('{in_result, in_rd, in_wr_en});
        end
    end

    always @(negedge clk) begin : compare
        logic [3:0] exp_flags;
        if (reset_n) begin
            exp_flags = (BYPASS && in_valid && (q.size() < 2) && in_flag_we)
                        ? {in_n, in_z, in_c, in_v} : m_flags;
            chk("out_valid", out_valid, q.size() > 0);
            chk("in_ready", in_ready, q.size() < 2);
            if (q.size() > 0) begin
                chk("out_result", out_result, q[0].result);
                chk("out_rd", out_rd, q[0].rd);
                chk("out_wr_en", out_wr_en, q[0].wr_en);
            end
            chk("flags", flags, exp_flags);
            chk("cond_true", cond_true, cond_eval(exp_flags, cond));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [15:0] r, input logic [2:0] rd,
                          input logic fwe, input logic [3:0] nzcv);
        in_valid   = v;
        in_result  = r;
        in_rd      = rd;
        in_wr_en   = 1'b1;
        in_flag_we = fwe;
        {in_n, in_z, in_c, in_v} = nzcv;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_result", out_result, 16'h0);
        chk("rst_out_rd", out_rd, 3'd0);
        chk("rst_out_wr_en", out_wr_en, 1'b0);
        chk("rst_flags", flags, 4'b0000);
        @(negedge clk);
        reset_n = 1'b1;

        // single result, latency 1
        cyc();
        set_in(1'b1, 16'h1234, 3'd3, 1'b0, 4'b0000);
        cyc();
        in_valid = 1'b0;
        chk("lat_valid", out_valid, 1'b1);
        chk("lat_result", out_result, 16'h1234);
        chk("lat_rd", out_rd, 3'd3);
        cyc();
        chk("lat_drain", out_valid, 1'b0);

        // full-throughput stream
        for (int k = 1; k <= 4; k++) begin
            set_in(1'b1, 16'(k), 3'(k), 1'b0, 4'b0000);
            cyc();
            chk("stream_ready", in_ready, 1'b1);
            chk("stream_result", out_result, 32'(k));
        end
        in_valid = 1'b0;
        cyc();

        // stall: fill both entries, third push is refused
        out_ready = 1'b0;
        set_in(1'b1, 16'hAAAA, 3'd1, 1'b0, 4'b0000);
        cyc();
        set_in(1'b1, 16'hBBBB, 3'd2, 1'b0, 4'b0000);
        cyc();
        chk("stall_ready", in_ready, 1'b0);
        set_in(1'b1, 16'hCCCC, 3'd4, 1'b0, 4'b0000);
        cyc();
        chk("stall_hold", out_result, 16'hAAAA);
        out_ready = 1'b1;
        #1;
        chk("drain_a", out_result, 16'hAAAA);
        cyc();
        chk("drain_b", out_result, 16'hBBBB);
        cyc();
        chk("drain_c", out_result, 16'hCCCC);
        in_valid = 1'b0;
        cyc();
        chk("drain_empty", out_valid, 1'b0);

        // flags from 5-7: N=1 Z=0 C=0 V=0
        set_in(1'b1, 16'hFFFE, 3'd5, 1'b1, 4'b1000);
        cyc();
        in_valid = 1'b0;
        chk("flags_sub", flags, 4'b1000);
        cond = 3'b011; #1;
        chk("cond_lt", cond_true, 1'b1);
        cond = 3'b101; #1;
        chk("cond_ltu", cond_true, 1'b1);
        cond = 3'b001; #1;
        chk("cond_eq", cond_true, 1'b0);
        cyc();
        set_in(1'b1, 16'h0001, 3'd6, 1'b0, 4'b0100);
        cyc();
        in_valid = 1'b0;
        chk("flags_nowe", flags, 4'b1000);
        cyc();

        // zero-cycle compare->branch only with the bypass build
        cond = 3'b001;
        set_in(1'b1, 16'h0000, 3'd7, 1'b1, 4'b0100);
        #1;
        chk("bypass_same", cond_true, BYPASS);
        cyc();
        in_valid = 1'b0;
        chk("bypass_next", cond_true, 1'b1);
        cyc();

        // randomized traffic checked by the compare process
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 3) != 0, 16'($urandom), 3'($urandom),
                   1'($urandom), 4'($urandom));
            in_wr_en  = 1'($urandom);
            out_ready = $urandom_range(0, 2) != 0;
            cond      = 3'($urandom);
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc();
        cyc();

        // async reset while stalled and full
        out_ready = 1'b0;
        set_in(1'b1, 16'h1111, 3'd1, 1'b1, 4'b1111);
        cyc();
        set_in(1'b1, 16'h2222, 3'd2, 1'b0, 4'b0000);
        cyc();
        in_valid = 1'b0;
        chk("pre_rst_full", in_ready, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_ready", in_ready, 1'b1);
        chk("arst_flags", flags, 4'b0000);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
